// File: rtl/trng_pkg.sv
// Shared types and defaults for the TRNG sequencer and its repetition-count monitor.
package trng_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        COLLECT,
        HOLD,
        FAULT
    } trng_state_e;

    localparam int unsigned TRNG_WIDTH_DEF         = 8;
    localparam int unsigned TRNG_SETTLE_CYCLES_DEF = 4;
    localparam int unsigned TRNG_RCT_LIMIT_DEF     = 16;
    // XOR/DFF stages between the latches and net_bit
    localparam int unsigned TRNG_NET_PIPE_DEPTH    = 2;

endpackage

// File: rtl/trng_rct_monitor.sv
// Repetition-count health test: flags fail when RCT_LIMIT identical samples arrive in a row.
module trng_rct_monitor #(
    parameter int unsigned RCT_LIMIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sample,
    input  logic update,
    input  logic clear,
    output logic fail
);

    localparam int unsigned RW = $clog2(RCT_LIMIT + 1);

    logic [RW-1:0] run_q;
    logic [RW-1:0] run_d;
    logic          last_q;

    // run_q == 0 means no previous sample, so the next one always starts a run of 1
    always_comb begin
        run_d = RW'(1);
        if (run_q != '0 && sample == last_q) begin
            run_d = (run_q == RW'(RCT_LIMIT)) ? run_q : run_q + RW'(1);
        end
    end

    assign fail = update && (run_d == RW'(RCT_LIMIT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q  <= '0;
            last_q <= 1'b0;
        end else if (clear) begin
            run_q  <= '0;
            last_q <= 1'b0;
        end else if (update) begin
            run_q  <= run_d;
            last_q <= sample;
        end
    end

endmodule

// File: rtl/trng_sequencer.sv
// Sequences the latch entropy network and packs its bit stream into valid/ready words.
// Define TRNG_HEALTH_EN to enable the repetition-count health test and FAULT state.
module trng_sequencer
    import trng_pkg::*;
#(
    parameter int unsigned WIDTH         = TRNG_WIDTH_DEF,
    parameter int unsigned SETTLE_CYCLES = TRNG_SETTLE_CYCLES_DEF,
    parameter int unsigned RCT_LIMIT     = TRNG_RCT_LIMIT_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req,
    input  logic             net_bit,
    output logic             net_en,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             fault,
    input  logic             clear_fault
);

    localparam int unsigned BCW = $clog2(WIDTH + 1);

    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("trng_sequencer: WIDTH out of range 2..32");
    end
    if (SETTLE_CYCLES < TRNG_NET_PIPE_DEPTH || SETTLE_CYCLES > 255) begin : g_bad_settle
        $error("trng_sequencer: SETTLE_CYCLES must cover the network pipeline and be <= 255");
    end
    if (RCT_LIMIT < 2 || RCT_LIMIT > 255) begin : g_bad_rct
        $error("trng_sequencer: RCT_LIMIT out of range 2..255");
    end

    trng_state_e      state_q, state_d;
    logic [7:0]       settle_q, settle_d;
    logic [BCW-1:0]   bitcnt_q, bitcnt_d;
    logic [WIDTH-2:0] shift_q, shift_d;
    logic [WIDTH-1:0] word;
    logic [WIDTH-1:0] out_data_d;
    logic             out_valid_d;
    logic             net_en_d;
    logic             xfer;
    logic             rct_fail;

    assign word = {shift_q, net_bit};
    assign xfer = out_valid && out_ready;
    assign busy = (state_q != IDLE);

`ifdef TRNG_HEALTH_EN
    trng_rct_monitor #(
        .RCT_LIMIT(RCT_LIMIT)
    ) u_rct (
        .clk    (clk),
        .rst_n  (rst_n),
        .sample (net_bit),
        .update (state_q == COLLECT),
        .clear  ((state_q == IDLE && req) || (state_q == FAULT && clear_fault)),
        .fail   (rct_fail)
    );
    assign fault = (state_q == FAULT);
`else
    assign rct_fail = 1'b0;
    assign fault    = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        settle_d    = settle_q;
        bitcnt_d    = bitcnt_q;
        shift_d     = shift_q;
        out_data_d  = out_data;
        out_valid_d = out_valid;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    state_d  = SETTLE;
                    settle_d = 8'(SETTLE_CYCLES - 1);
                end
            end
            SETTLE: begin
                settle_d = (settle_q != '0) ? settle_q - 8'd1 : settle_q;
                if (!req) begin
                    state_d = IDLE;
                end else if (settle_q <= 8'd1) begin
                    // leave as the count reaches zero so the first sample lands SETTLE_CYCLES after net_en rises
                    state_d  = COLLECT;
                    bitcnt_d = '0;
                end
            end
            COLLECT: begin
                if (rct_fail) begin
                    state_d = FAULT;
                end else if (!req) begin
                    state_d = IDLE;
                end else begin
                    shift_d  = word[WIDTH-2:0];
                    bitcnt_d = bitcnt_q + BCW'(1);
                    if (bitcnt_q == BCW'(WIDTH - 1)) begin
                        out_data_d  = word;
                        out_valid_d = 1'b1;
                        state_d     = HOLD;
                    end
                end
            end
            HOLD: begin
                if (xfer) begin
                    out_valid_d = 1'b0;
                    bitcnt_d    = '0;
                    state_d     = req ? COLLECT : IDLE;
                end
            end
            FAULT: begin
                out_valid_d = 1'b0;
                if (clear_fault) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        unique case (state_d)
            SETTLE, COLLECT: net_en_d = 1'b1;
            HOLD:            net_en_d = net_en;
            default:         net_en_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            settle_q  <= '0;
            bitcnt_q  <= '0;
            shift_q   <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            net_en    <= 1'b0;
        end else begin
            state_q   <= state_d;
            settle_q  <= settle_d;
            bitcnt_q  <= bitcnt_d;
            shift_q   <= shift_d;
            out_data  <= out_data_d;
            out_valid <= out_valid_d;
            net_en    <= net_en_d;
        end
    end

endmodule

// File: tb/tb_trng_sequencer.sv
// Directed, table-driven bench for trng_sequencer (default parameters).
module tb_trng_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req;
    logic       net_bit;
    logic       net_en;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
    logic       fault;
    logic       clear_fault;

    int unsigned errors = 0;
    int unsigned checks = 0;

    always #5 clk = ~clk;

    trng_sequencer #(
        .WIDTH(8),
        .SETTLE_CYCLES(4),
        .RCT_LIMIT(16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .net_bit     (net_bit),
        .net_en      (net_en),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .busy        (busy),
        .fault       (fault),
        .clear_fault (clear_fault)
    );

    typedef struct {
        logic       req;
        logic       nb;
        logic       rdy;
        logic       en;
        logic       vld;
        logic       busy;
        logic [7:0] data;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void add(input logic r, input logic b, input logic y,
                                input logic e, input logic v, input logic bz,
                                input logic [7:0] d);
        vec_t t;
        t.req = r; t.nb = b; t.rdy = y; t.en = e; t.vld = v; t.busy = bz; t.data = d;
        vecs.push_back(t);
    endfunction

    // Eight COLLECT cycles feeding w MSB first; valid appears on the last one.
    function automatic void add_word(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) add(1'b1, w[i], 1'b1, 1'b1, i == 0, 1'b1, w);
    endfunction

    initial begin
        rst_n = 1'b0; req = 1'b0; net_bit = 1'b0; out_ready = 1'b0; clear_fault = 1'b0;
        #12;
        chk("reset net_en", {31'b0, net_en}, 0);
        chk("reset out_valid", {31'b0, out_valid}, 0);
        chk("reset out_data", {24'b0, out_data}, 0);
        chk("reset busy", {31'b0, busy}, 0);
        chk("reset fault", {31'b0, fault}, 0);
        rst_n = 1'b1;
        step();
        chk("idle busy", {31'b0, busy}, 0);

        // Edge k: enter SETTLE; k+1..k+3 settle; samples k+4..k+11.
        add(1, 0, 1, 1, 0, 1, 8'h00);
        for (int i = 0; i < 3; i++) add(1, 0, 1, 1, 0, 1, 8'h00);
        add_word(8'hAA);
        // Held with out_ready low while net_bit toggles.
        for (int i = 0; i < 5; i++) add(1, i[0], 0, 1, 1, 1, 8'hAA);
        add(1, 0, 1, 1, 0, 1, 8'h00);
        add_word(8'h3C);
        add(1, 0, 1, 1, 0, 1, 8'h00);
        add_word(8'hC5);
        add(0, 0, 1, 0, 0, 0, 8'h00);

        for (int i = 0; i < vecs.size(); i++) begin
            req = vecs[i].req; net_bit = vecs[i].nb; out_ready = vecs[i].rdy;
            step();
            chk($sformatf("row%0d net_en", i), {31'b0, net_en}, {31'b0, vecs[i].en});
            chk($sformatf("row%0d out_valid", i), {31'b0, out_valid}, {31'b0, vecs[i].vld});
            chk($sformatf("row%0d busy", i), {31'b0, busy}, {31'b0, vecs[i].busy});
            if (vecs[i].vld)
                chk($sformatf("row%0d out_data", i), {24'b0, out_data}, {24'b0, vecs[i].data});
        end

        // Abort after three samples, then a fresh word after resettling.
        req = 1'b1; net_bit = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 7; i++) step();
        req = 1'b0;
        step();
        chk("abort net_en", {31'b0, net_en}, 0);
        chk("abort busy", {31'b0, busy}, 0);
        chk("abort out_valid", {31'b0, out_valid}, 0);
        step();
        chk("abort idle valid", {31'b0, out_valid}, 0);
        begin
            logic [7:0] w;
            w = 8'h96;
            req = 1'b1;
            for (int i = 0; i < 12; i++) begin
                net_bit = (i >= 4) ? w[11 - i] : 1'b0;
                step();
                if (i == 0) chk("refill net_en", {31'b0, net_en}, 1);
                if (i < 11) chk($sformatf("refill valid@%0d", i), {31'b0, out_valid}, 0);
            end
            chk("refill out_valid", {31'b0, out_valid}, 1);
            chk("refill out_data", {24'b0, out_data}, {24'b0, w});
        end
        req = 1'b0;
        step();
        chk("refill drop busy", {31'b0, busy}, 0);

        // Asynchronous reset mid-COLLECT.
        req = 1'b1; net_bit = 1'b0;
        for (int i = 0; i < 6; i++) step();
        #2 rst_n = 1'b0;
        #1;
        chk("rst collect net_en", {31'b0, net_en}, 0);
        chk("rst collect busy", {31'b0, busy}, 0);
        chk("rst collect valid", {31'b0, out_valid}, 0);
        #1 rst_n = 1'b1;
        req = 1'b0;
        step();
        chk("rst collect idle busy", {31'b0, busy}, 0);

        // Asynchronous reset while holding a word.
        req = 1'b1; out_ready = 1'b0; net_bit = 1'b1;
        for (int i = 0; i < 12; i++) step();
        chk("hold before rst valid", {31'b0, out_valid}, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst hold valid", {31'b0, out_valid}, 0);
        chk("rst hold data", {24'b0, out_data}, 0);
        chk("rst hold net_en", {31'b0, net_en}, 0);
        #1 rst_n = 1'b1;
        req = 1'b0; out_ready = 1'b1;
        step();
        chk("rst hold idle busy", {31'b0, busy}, 0);
        chk("rst hold idle net_en", {31'b0, net_en}, 0);

`ifdef TRNG_HEALTH_EN
        // Constant 1s: first word FF, 16th sample lands on the last bit of word two.
        req = 1'b1; out_ready = 1'b1; net_bit = 1'b1;
        for (int i = 0; i < 21; i++) begin
            step();
            if (i == 11) chk("rct word data", {24'b0, out_data}, 32'hFF);
            if (i == 19) chk("rct pre fault", {31'b0, fault}, 0);
        end
        chk("rct fault", {31'b0, fault}, 1);
        chk("rct net_en", {31'b0, net_en}, 0);
        chk("rct valid", {31'b0, out_valid}, 0);
        clear_fault = 1'b1;
        step();
        chk("clear fault", {31'b0, fault}, 0);
        chk("clear busy", {31'b0, busy}, 0);
        clear_fault = 1'b0;
        step();
        chk("after clear settle", {31'b0, net_en}, 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/trng_sequencer.md
# trng_sequencer

Controller that sequences the SR-latch entropy network and turns its one-bit-per-cycle output into handshaked WIDTH-bit words. It raises the network enable on request, waits for the latches and the network's two-stage XOR/DFF pipeline to settle, then shifts in WIDTH samples. It presents each word on a valid/ready port and optionally runs a repetition-count health test. It sits between the entropy network and any consumer (UIO/output register logic).

## Interface
Parameters:
- WIDTH, 8: bits per output word; legal 2..32.
- SETTLE_CYCLES, 4: cycles net_en is high before the first sample; legal 2..255. Must be at least the network pipeline depth of 2.
- RCT_LIMIT, 16: consecutive identical samples that declare a fault; legal 2..255.

Ports:
- Clock and reset: one clock, `clk`; reset is asynchronous and active-low, `rst_n`.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- req  in  1  level; high = keep producing words.
- net_bit  in  1  entropy bit from the latch network (its `b` output).
- net_en  out  1  registered enable to the latch network.
- out_data  out  WIDTH  collected word, MSB = oldest sample.
- out_valid  out  1  word available.
- out_ready  in  1  consumer accepts; transfer when out_valid && out_ready at a clk edge.
- busy  out  1  state != IDLE.
- fault  out  1  sticky health-test failure (tied 0 without the macro).
- clear_fault  in  1  pulse; leaves FAULT.

## Operation
- States: IDLE, SETTLE, COLLECT, HOLD, FAULT.
- Reset: state IDLE; net_en=0, out_valid=0, out_data=0, busy=0, fault=0; all counters cleared.
- IDLE: net_en=0. If req=1, go to SETTLE and load the settle counter with SETTLE_CYCLES-1.
- SETTLE: net_en=1. Counter decrements each cycle. At 0, go to COLLECT with bit counter=0. If req=0, go to IDLE.
- COLLECT: net_en=1. Each cycle, shift = {shift[WIDTH-2:0], net_bit}; bit counter +1.
  - On the WIDTH-th sample, copy into out_data, set out_valid, go to HOLD.
  - If req=0, go to IDLE and discard the partial word.
- HOLD: net_en stays at its current value; net_bit is ignored and the RCT is frozen. out_valid and out_data are stable until transfer.
  - On transfer with req=1: go to COLLECT with bit counter=0; no resettle.
  - On transfer with req=0: go to IDLE.
  - req dropping without out_ready does not withdraw out_valid.
- FAULT: net_en=0, out_valid=0, fault=1. clear_fault=1 goes to IDLE, clears fault and the RCT counter. req is ignored.
- Health test (macro on):
  - Tracks the last sample and a run counter, updated only in COLLECT.
  - A sample equal to the last increments the run counter (saturating); a differing sample sets it to 1.
  - When the run reaches RCT_LIMIT, go to FAULT instead of any other transition; the partial word is discarded.
  - The run counter clears on entering SETTLE.
- Arithmetic:
  - The bit counter is $clog2(WIDTH+1) bits.
  - The RCT counter is $clog2(RCT_LIMIT+1) bits.
  - No wrap: counters reload on state entry.

## Timing
- All outputs are registered.
- req sampled high in IDLE at edge k:
  - net_en rises at k.
  - The first sample is taken at edge k+SETTLE_CYCLES.
  - out_valid rises at k+SETTLE_CYCLES+WIDTH-1 (defaults: k+11).
- Back-to-back: transfer at edge m with req=1 gives the next out_valid at m+WIDTH. Sustained throughput is WIDTH/(WIDTH+1) bits per cycle.
- If the same edge sees abort conditions, priority is reset > FAULT detection > req=0 abort > normal progress.
- clear_fault and req both high in FAULT: go to IDLE; SETTLE starts on the following edge.
- Asynchronous reset mid-word: outputs drop immediately and the word is lost.

## Configuration
- TRNG_HEALTH_EN defined: RCT logic, FAULT state and clear_fault are active.
- TRNG_HEALTH_EN undefined: the RCT logic is removed, FAULT is unreachable, fault is tied 0, and clear_fault is ignored. All other timing is identical.

## Structure
- Package trng_pkg holds:
  - The state enum typedef (IDLE, SETTLE, COLLECT, HOLD, FAULT).
  - Default constants for WIDTH, SETTLE_CYCLES and RCT_LIMIT.
  - The network pipeline depth constant (2), used in a parameter assertion.
- One sub-module, trng_rct_monitor: sample, update strobe and clear in; fail out. It is instantiated only under TRNG_HEALTH_EN.
- The latch network itself is instantiated by the parent, not inside this block.

## Test plan
- Defaults, req=1, out_ready=1, net_bit = alternating 1,0,… from the first sample → out_valid at edge k+11, out_data=8'hAA, net_en high from k.
- out_ready=0 for 5 cycles after valid, with net_bit changing → out_data and out_valid held stable; no RCT update; transfer completes when out_ready rises.
- req drops after 3 COLLECT samples → IDLE next edge, net_en=0, no out_valid. A later req yields a full fresh word after resettling.
- Macro on, RCT_LIMIT=16, net_bit held 1 → fault=1 and FAULT on the 16th sample, net_en=0. clear_fault → IDLE, fault=0.
- Continuous req with out_ready=1 → words spaced WIDTH+1 cycles apart, only one SETTLE phase at the start.
- rst_n asserted in HOLD and in COLLECT → all outputs 0 asynchronously. After release, IDLE with busy=0.
